// File: rtl/forward_scoreboard_pkg.sv
// Shared definitions for the forwarding scoreboard.
//   REG_AW_DEF / CNT_W_DEF : default register-address and counter widths
//   fwd_sel_e              : EX operand select encoding (regfile, EX/MEM, MEM/WB)
package forward_scoreboard_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/forward_scoreboard_fwd_sel.sv
// Priority compare of one source register against the two newest in-flight
// destination records.
//   src                  : source register read by the ID instruction
//   ex_rd / ex_reg_write : record currently in EX (becomes MEM next cycle)
//   mem_rd/mem_reg_write : record currently in MEM (becomes WB next cycle)
//   sel                  : FWD_EXMEM, FWD_MEMWB or FWD_REG; $0 never forwards
module forward_scoreboard_fwd_sel
  import forward_scoreboard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  output fwd_sel_e          sel
);

  always_comb begin
    sel = FWD_REG;
    if (src != '0) begin
      if (ex_reg_write && (ex_rd == src)) begin
        sel = FWD_EXMEM;
      end else if (mem_reg_write && (mem_rd == src)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// Forwarding scoreboard: shadows EX/MEM/WB destination records, registers the
// EX operand forwarding selects and flags WB->ID bypass hits.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   stall_i, flush_i        : either one inserts a bubble into EX
//   id_rs_i/id_rt_i/id_rd_i : ID-stage register fields
//   id_RegWrite_i/id_MemRead_i : ID-stage control
//   ForwardA_o/ForwardB_o   : registered EX operand selects
//   id_bypass_rs_o/_rt_o    : combinational WB-write hits on ID sources
//   fwd_err_o               : sticky, forward from an unresolved load needed
//   fwd_cnt_o               : saturating count of cycles with any forward
module forward_scoreboard
  import forward_scoreboard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_RegWrite_i,
  input  logic              id_MemRead_i,
  output logic [1:0]        ForwardA_o,
  output logic [1:0]        ForwardB_o,
  output logic              id_bypass_rs_o,
  output logic              id_bypass_rt_o,
  output logic              fwd_err_o,
  output logic [CNT_W-1:0]  fwd_cnt_o
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } rec_t;

  rec_t     id_rec;
  rec_t     ex_q;
  rec_t     mem_q;
  rec_t     wb_q;
  logic     bubble;
  fwd_sel_e sel_a;
  fwd_sel_e sel_b;

  always_comb begin
    id_rec = '{rd: id_rd_i, reg_write: id_RegWrite_i, mem_read: id_MemRead_i,
               rs: id_rs_i, rt: id_rt_i};
  end

  assign bubble = stall_i | flush_i;

  // Compare against the current EX/MEM records: they are exactly what sits in
  // MEM/WB when the ID instruction reaches EX next cycle.
  forward_scoreboard_fwd_sel #(.REG_AW(REG_AW)) u_sel_rs (
    .src           (id_rs_i),
    .ex_rd         (ex_q.rd),
    .ex_reg_write  (ex_q.reg_write),
    .mem_rd        (mem_q.rd),
    .mem_reg_write (mem_q.reg_write),
    .sel           (sel_a)
  );

  forward_scoreboard_fwd_sel #(.REG_AW(REG_AW)) u_sel_rt (
    .src           (id_rt_i),
    .ex_rd         (ex_q.rd),
    .ex_reg_write  (ex_q.reg_write),
    .mem_rd        (mem_q.rd),
    .mem_reg_write (mem_q.reg_write),
    .sel           (sel_b)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      ForwardA_o <= FWD_REG;
      ForwardB_o <= FWD_REG;
      fwd_err_o  <= 1'b0;
      fwd_cnt_o  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= bubble ? rec_t'('0) : id_rec;

      if (bubble) begin
        ForwardA_o <= FWD_REG;
        ForwardB_o <= FWD_REG;
      end else begin
        ForwardA_o <= sel_a;
        ForwardB_o <= sel_b;
        // An EX/MEM forward from a load means the data is not yet available.
        if (ex_q.mem_read && ((sel_a == FWD_EXMEM) || (sel_b == FWD_EXMEM))) begin
          fwd_err_o <= 1'b1;
        end
      end

      if (((ForwardA_o != FWD_REG) || (ForwardB_o != FWD_REG)) && (fwd_cnt_o != '1)) begin
        fwd_cnt_o <= fwd_cnt_o + 1'b1;
      end
    end
  end

  assign id_bypass_rs_o = wb_q.reg_write && (wb_q.rd == id_rs_i) && (id_rs_i != '0);
  assign id_bypass_rt_o = wb_q.reg_write && (wb_q.rd == id_rt_i) && (id_rt_i != '0);

  // Source fields and downstream load flags ride along for debug visibility only.
  logic unused_rec_bits;
  assign unused_rec_bits = ^{ex_q.rs, ex_q.rt, mem_q.mem_read, mem_q.rs, mem_q.rt,
                             wb_q.mem_read, wb_q.rs, wb_q.rt};

endmodule

// File: tb/tb_forward_scoreboard.sv
module tb_forward_scoreboard;

  localparam int AW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_i, stall_i, flush_i;
  logic [AW-1:0] id_rs_i, id_rt_i, id_rd_i;
  logic          id_RegWrite_i, id_MemRead_i;
  logic [1:0]    ForwardA_o, ForwardB_o;
  logic          id_bypass_rs_o, id_bypass_rt_o, fwd_err_o;
  logic [CW-1:0] fwd_cnt_o;

  always #5 clk = ~clk;

  forward_scoreboard #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_rd_i        (id_rd_i),
    .id_RegWrite_i  (id_RegWrite_i),
    .id_MemRead_i   (id_MemRead_i),
    .ForwardA_o     (ForwardA_o),
    .ForwardB_o     (ForwardB_o),
    .id_bypass_rs_o (id_bypass_rs_o),
    .id_bypass_rt_o (id_bypass_rt_o),
    .fwd_err_o      (fwd_err_o),
    .fwd_cnt_o      (fwd_cnt_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: history of instructions that entered EX, newest first.
  // Index 0 = in EX, 1 = in MEM, 2 = in WB.
  typedef struct {
    logic [AW-1:0] rd;
    bit            we;
    bit            ld;
  } m_rec_t;

  m_rec_t hist[$];
  int     exp_a, exp_b, exp_cnt;
  bit     exp_err;

  function automatic m_rec_t bub();
    m_rec_t b;
    b.rd = '0; b.we = 0; b.ld = 0;
    return b;
  endfunction

  function automatic int want_sel(input logic [AW-1:0] r);
    if (r == 0) return 0;
    if (hist[0].we && hist[0].rd == r) return 2;
    if (hist[1].we && hist[1].rd == r) return 1;
    return 0;
  endfunction

  function automatic bit want_byp(input logic [AW-1:0] r);
    return (r != 0) && hist[2].we && (hist[2].rd == r);
  endfunction

  task automatic cyc(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                     input logic [AW-1:0] rd, input bit we, input bit ld,
                     input bit stall, input bit flush, input bit rst, input bit chk);
    int     na, nb;
    m_rec_t nr;
    rst_i = rst; stall_i = stall; flush_i = flush;
    id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
    id_RegWrite_i = we; id_MemRead_i = ld;
    #1;
    if (chk) begin
      check("byp_rs", id_bypass_rs_o, want_byp(rs));
      check("byp_rt", id_bypass_rt_o, want_byp(rt));
    end
    if (rst) begin
      hist = '{bub(), bub(), bub()};
      exp_a = 0; exp_b = 0; exp_err = 0; exp_cnt = 0;
    end else begin
      if ((exp_a != 0 || exp_b != 0) && exp_cnt < (1 << CW) - 1) exp_cnt++;
      if (stall || flush) begin
        na = 0; nb = 0; nr = bub();
      end else begin
        na = want_sel(rs); nb = want_sel(rt);
        if ((na == 2 || nb == 2) && hist[0].ld) exp_err = 1;
        nr.rd = rd; nr.we = we; nr.ld = ld;
      end
      hist.push_front(nr);
      void'(hist.pop_back());
      exp_a = na; exp_b = nb;
    end
    @(posedge clk);
    #1;
    if (chk) begin
      check("fwd_a", ForwardA_o, exp_a);
      check("fwd_b", ForwardB_o, exp_b);
      check("err", fwd_err_o, exp_err);
      check("cnt", fwd_cnt_o, exp_cnt);
    end
  endtask

  task automatic instr(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] rd, input bit we, input bit ld);
    cyc(rs, rt, rd, we, ld, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
    check("rst_fa", ForwardA_o, 0);
    check("rst_fb", ForwardB_o, 0);
    check("rst_err", fwd_err_o, 0);
    check("rst_cnt", fwd_cnt_o, 0);
  endtask

  initial begin
    hist = '{bub(), bub(), bub()};
    exp_a = 0; exp_b = 0; exp_err = 0; exp_cnt = 0;

    do_reset();
    do_reset();

    // Back-to-back dependency on $3.
    instr(1, 2, 3, 1, 0);
    instr(3, 1, 8, 1, 0);
    check("t1_fa", ForwardA_o, 2'b10);
    check("t1_cnt0", fwd_cnt_o, 0);
    instr(0, 0, 0, 0, 0);
    check("t1_cnt1", fwd_cnt_o, 1);

    // One-instruction gap on $4 via rt.
    instr(1, 2, 4, 1, 0);
    instr(0, 0, 0, 0, 0);
    instr(9, 4, 10, 1, 0);
    check("t2_fb", ForwardB_o, 2'b01);

    // Two writers of $5: newest wins.
    instr(1, 2, 5, 1, 0);
    instr(1, 2, 5, 1, 0);
    instr(5, 0, 11, 1, 0);
    check("t3_fa", ForwardA_o, 2'b10);

    // Load-use with stall: bubble then MEM/WB forward, no error.
    instr(1, 2, 6, 1, 1);
    cyc(6, 0, 12, 1, 0, 1, 0, 0, 1);
    check("t4_bub_fa", ForwardA_o, 2'b00);
    check("t4_bub_fb", ForwardB_o, 2'b00);
    instr(6, 0, 12, 1, 0);
    check("t4_fa", ForwardA_o, 2'b01);
    check("t4_err0", fwd_err_o, 0);

    // Same without stall: EX/MEM forward from load sets sticky error.
    instr(1, 2, 6, 1, 1);
    instr(6, 0, 12, 1, 0);
    check("t5_fa", ForwardA_o, 2'b10);
    check("t5_err", fwd_err_o, 1);
    instr(0, 0, 0, 0, 0);
    instr(0, 0, 0, 0, 0);
    check("t5_err_hold", fwd_err_o, 1);

    // $0 writes never forward.
    instr(1, 2, 0, 1, 0);
    instr(0, 0, 13, 1, 0);
    check("t6_fa", ForwardA_o, 2'b00);
    check("t6_fb", ForwardB_o, 2'b00);

    // WB bypass on rt = $7.
    instr(1, 2, 7, 1, 0);
    instr(0, 0, 0, 0, 0);
    instr(0, 0, 0, 0, 0);
    id_rs_i = 1; id_rt_i = 7; id_rd_i = 14; id_RegWrite_i = 1; id_MemRead_i = 0;
    rst_i = 0; stall_i = 0; flush_i = 0;
    #1;
    check("t7_byp_rt", id_bypass_rt_o, 1);
    check("t7_byp_rs", id_bypass_rs_o, 0);
    instr(1, 7, 14, 1, 0);

    // Flush acts like a bubble.
    instr(1, 2, 9, 1, 0);
    cyc(9, 9, 15, 1, 0, 0, 1, 0, 1);
    check("t8_flush_fa", ForwardA_o, 2'b00);

    // Mid-stream reset with live forwarding and sticky error.
    instr(1, 2, 6, 1, 1);
    instr(6, 6, 12, 1, 0);
    do_reset();
    instr(6, 6, 3, 1, 0);
    check("t9_empty_fa", ForwardA_o, 2'b00);

    // Counter saturation with continuous self-dependency on $3.
    do_reset();
    for (int i = 0; i < 65540; i++) begin
      cyc(3, 3, 3, 1, 0, 0, 0, 0, (i > 65525));
    end
    check("t10_sat", fwd_cnt_o, 16'hFFFF);
    instr(3, 3, 3, 1, 0);
    check("t10_hold", fwd_cnt_o, 16'hFFFF);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
          AW'($urandom_range(0, 7)), ($urandom_range(0, 99) < 70),
          ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 15),
          ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 2), 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
